// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings, fill modes
// and small decode helpers used by the datapath.
package shifter_pkg;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t OP_SLL = 3'b000;
  localparam shift_op_t OP_SRL = 3'b001;
  localparam shift_op_t OP_SRA = 3'b010;
  localparam shift_op_t OP_ROL = 3'b011;
  localparam shift_op_t OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_WRAP = 2'd2
  } fill_t;

  // Left ops run through the right-shift datapath on bit-reversed data.
  function automatic logic op_is_left(input shift_op_t op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic op_is_known(input shift_op_t op);
    return op <= OP_ROR;
  endfunction

  function automatic fill_t op_fill(input shift_op_t op);
    case (op)
      OP_SRA:         return FILL_SIGN;
      OP_ROL, OP_ROR: return FILL_WRAP;
      default:        return FILL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/shifter_level.sv
// One logarithmic mux level: optionally right-shifts by DIST, filling the
// vacated MSBs with zeros, the sign bit, or the bits shifted out.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  fill_t            fill,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  logic [DIST-1:0] fill_bits;

  always_comb begin
    fill_bits = '0;
    case (fill)
      FILL_SIGN: fill_bits = {DIST{sign}};
      FILL_WRAP: fill_bits = data[DIST-1:0];
      default:   fill_bits = '0;
    endcase
    result = en ? {fill_bits, data[WIDTH-1:DIST]} : data;
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: $clog2(WIDTH) right-shift levels spread over PIPE
// register stages with a valid/ready handshake at both ends.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LV  = $clog2(WIDTH);
  localparam int LPS = (LV + PIPE - 1) / PIPE;

  // Handshake: a transfer happens on any edge where valid & ready are both
  // high; stage i moves when it is empty or stage i+1 moves, and the last
  // stage moves when out_valid is low or out_ready is high.

  logic [WIDTH-1:0] r_data [PIPE];
  logic [LV-1:0]    r_amt  [PIPE];
  shift_op_t        r_op   [PIPE];
  logic             r_sign [PIPE];
  logic [TAG_W-1:0] r_tag  [PIPE];
  logic [PIPE-1:0]  r_valid;

  logic [WIDTH-1:0] nxt_data [PIPE];
  logic [LV-1:0]    c_amt    [PIPE];
  shift_op_t        c_op     [PIPE];
  logic             c_sign   [PIPE];
  logic [TAG_W-1:0] c_tag    [PIPE];

  logic [PIPE:0]    adv;
  logic [PIPE-1:0]  vin;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  always_comb begin
    adv       = '0;
    adv[PIPE] = out_ready;
    for (int s = PIPE - 1; s >= 0; s--) adv[s] = ~r_valid[s] | adv[s+1];
  end

  assign in_ready = adv[0] & ~flush;

  always_comb begin
    vin    = '0;
    vin[0] = in_valid & in_ready;
    for (int s = 1; s < PIPE; s++) vin[s] = r_valid[s-1];
  end

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    localparam int LO = s * LPS;
    localparam int NL = (LO >= LV) ? 0 : ((LV - LO < LPS) ? (LV - LO) : LPS);

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    fill_t            fill;

    if (s == 0) begin : g_head
      // Reserved ops pass through by forcing a zero shift amount.
      assign din      = op_is_left(in_op) ? bit_rev(in_data) : in_data;
      assign c_amt[0] = op_is_known(in_op) ? in_amt : '0;
      assign c_op[0]  = in_op;
      assign c_sign[0] = in_data[WIDTH-1];
      assign c_tag[0] = in_tag;
    end else begin : g_body
      assign din       = r_data[s-1];
      assign c_amt[s]  = r_amt[s-1];
      assign c_op[s]   = r_op[s-1];
      assign c_sign[s] = r_sign[s-1];
      assign c_tag[s]  = r_tag[s-1];
    end

    assign fill = op_fill(c_op[s]);

    for (genvar j = 0; j < NL; j++) begin : g_level
      logic [WIDTH-1:0] lin;
      logic [WIDTH-1:0] lout;
      if (j == 0) begin : g_first
        assign lin = din;
      end else begin : g_next
        assign lin = g_level[j-1].lout;
      end
      shifter_level #(
        .WIDTH(WIDTH),
        .DIST (1 << (LO + j))
      ) u_level (
        .data  (lin),
        .en    (c_amt[s][LO+j]),
        .fill  (fill),
        .sign  (c_sign[s]),
        .result(lout)
      );
    end

    if (NL == 0) begin : g_empty
      assign dout = din;
    end else begin : g_tail
      assign dout = g_level[NL-1].lout;
    end

    if (s == PIPE - 1) begin : g_out
      assign nxt_data[s] = op_is_left(c_op[s]) ? bit_rev(dout) : dout;
    end else begin : g_mid
      assign nxt_data[s] = dout;
    end
  end

  // Payload registers load only when a valid op moves in, so a stalled or
  // draining pipe does not toggle the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE; s++) begin
        r_data[s] <= '0;
        r_amt[s]  <= '0;
        r_op[s]   <= OP_SLL;
        r_sign[s] <= 1'b0;
        r_tag[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE; s++) begin
        if (flush)       r_valid[s] <= 1'b0;
        else if (adv[s]) r_valid[s] <= vin[s];
        if (adv[s] && vin[s] && !flush) begin
          r_data[s] <= nxt_data[s];
          r_amt[s]  <= c_amt[s];
          r_op[s]   <= c_op[s];
          r_sign[s] <= c_sign[s];
          r_tag[s]  <= c_tag[s];
        end
      end
    end
  end

  assign out_valid = r_valid[PIPE-1];
  assign out_data  = r_data[PIPE-1];
  assign out_tag   = r_tag[PIPE-1];

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter for the execute-stage ALU.
- Supports logical/arithmetic shifts and rotates in both directions.
- Logarithmic mux levels are distributed across PIPE register stages, with valid/ready handshake at both ends.
- Successor to the fixed 8-bit combinational left shifter: adds width, direction, mode, pipelining and backpressure.

Parameters:
- WIDTH, 32: data width; must be a power of two, ≥ 8.
- PIPE, 2: register stages (1..$clog2(WIDTH)); latency = PIPE cycles.
- TAG_W, 5: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset; asynchronous, active-low.
- flush  in  1: synchronous pipeline clear.
- in_valid  in  1: input operation valid.
- in_ready  out  1: shifter can accept an input this cycle.
- in_op  in  3: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101–111 reserved.
- in_amt  in  $clog2(WIDTH): shift amount, unsigned.
- in_data  in  WIDTH: operand.
- in_tag  in  TAG_W: sideband tag, passed through unchanged.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result this cycle.
- out_data  out  WIDTH: result.
- out_tag  out  TAG_W: tag of the operation in out_data.

Behaviour:
- **Reset:** while rst_n = 0, all stage valid bits, out_valid, out_data and out_tag are 0. in_ready = 1 one cycle after reset release.
- **Result definition:** in_amt is interpreted modulo WIDTH (inherent to the port width).
  - SLL: zero-fill from LSB.
  - SRL: zero-fill from MSB.
  - SRA: fill with in_data[WIDTH-1].
  - ROL / ROR: bits wrap around.
  - in_amt = 0 → out_data = in_data for every op.
  - Reserved op → out_data = in_data.
- **Datapath structure:**
  - Left ops use a bit-reverse → right shift → bit-reverse scheme.
  - Fill source per level: zero, sign, or wrapped bits.
  - $clog2(WIDTH) mux levels; level k shifts by 2^k when amt[k] = 1.
  - Levels are split over PIPE stages, with ceil(levels/PIPE) levels before each register. The last register drives out_*.
  - Per stage, the following are registered: partial data, remaining amt bits, op, sign, tag, valid.
- **Handshake:**
  - Stage i advances when it is empty, or when stage i+1 advances. The last stage advances when out_valid = 0 or out_ready = 1.
  - in_ready = ~valid[0] | advance[0]; it is combinational from out_ready through the chain.
  - A transfer occurs when in_valid & in_ready.
  - Full throughput: one op per cycle while out_ready = 1.
  - Latency from accept to out_valid = PIPE cycles.
- **Backpressure:**
  - While out_valid = 1 and out_ready = 0, out_data and out_tag are held stable.
  - No result is dropped or duplicated; results are delivered in order.
  - With out_ready held low, at most PIPE ops are accepted before in_ready = 0.
- **Flush:**
  - Next edge clears every valid bit, including out_valid.
  - An input presented in the same cycle as flush is discarded, not accepted.
  - in_ready is forced to 0 during flush.
- **Simultaneous events:**
  - Accept in the same cycle as output drain keeps occupancy constant.
  - rst_n assertion mid-operation discards all in-flight ops immediately (asynchronous).
- **Data gating:** data registers update only on advance, so there is no toggling when stalled.

Decomposition:
- Package shifter_pkg: op encoding constants (OP_SLL..OP_ROR) and a shift_op_t typedef.
- Sub-module shifter_level: one combinational mux level, parameters WIDTH and DIST, inputs data/en/fill-mode. Instantiated $clog2(WIDTH) times via generate.
- Stage registers and handshake logic live in shifter_pipe.

Test Plan:
- WIDTH=32, PIPE=2, SRA 0x80000000 by 4, tag 3 → out_data 0xF8000000, out_tag 3, out_valid exactly 2 cycles after accept.
- SLL 0x00000001 by 31 → 0x80000000; SRL 0x80000000 by 31 → 0x00000001; ROL 0x80000001 by 1 → 0x00000003; ROR 0x00000001 by 1 → 0x80000000.
- Back-to-back stream of 8 ops (tags 0..7, amt = tag) with out_ready = 1 → 8 results on 8 consecutive cycles, in order; then op 101 with data 0x12345678 → 0x12345678.
- Continuous in_valid with out_ready = 0 for 5 cycles:
  - in_ready falls after 2 accepts; out_data held stable.
  - On out_ready = 1, all results emerge in order with no loss.
- Two ops in flight, flush pulsed one cycle → out_valid = 0 next cycle, and no result from those ops ever appears; op presented during flush is not accepted.
- rst_n dropped asynchronously mid-stream → out_valid = 0 immediately; after release, a fresh SLL 0xA by 4 → 0xA0 with correct 2-cycle latency.
